// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci term generator.
package fib_pkg;

  localparam int FIB_N_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_e;

endpackage

// File: rtl/fib_gen.sv
// Fibonacci term generator: streams 0,1,1,2,... over a valid/ready port until
// the next term no longer fits in n bits, then parks in DONE until restarted.
module fib_gen
  import fib_pkg::*;
#(
  parameter int n = FIB_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         ready,
  output logic         valid,
  output logic [n-1:0] fib,
  output logic [n-1:0] idx,
  output logic         done,
  output fib_state_e   state_dbg
);

  // Handshake: a term transfers on every rising edge where valid && ready.
  // While valid is high and ready is low, fib/idx are held stable.

  fib_state_e   state_q, state_d;
  logic [n:0]   b_q, b_d;
  logic [n-1:0] fib_d, idx_d;
  logic         valid_d, done_d;
  logic [n:0]   sum;

  localparam logic [n:0]   B_INIT  = {{n{1'b0}}, 1'b1};
  localparam logic [n-1:0] IDX_ONE = {{(n-1){1'b0}}, 1'b1};

  // n+1 bits wide so the first term that overflows n bits is still visible.
  assign sum = {1'b0, fib} + b_q;

  always_comb begin
    state_d = state_q;
    fib_d   = fib;
    idx_d   = idx;
    b_d     = b_q;
    valid_d = valid;
    done_d  = done;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          fib_d   = '0;
          idx_d   = '0;
          b_d     = B_INIT;
          valid_d = 1'b1;
          done_d  = 1'b0;
        end
      end
      RUN: begin
        if (ready) begin
          if (b_q[n]) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            fib_d = b_q[n-1:0];
            b_d   = sum;
            idx_d = idx + IDX_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fib     <= '0;
      idx     <= '0;
      b_q     <= B_INIT;
      valid   <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      fib     <= fib_d;
      idx     <= idx_d;
      b_q     <= b_d;
      valid   <= valid_d;
      done    <= done_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_fib_gen.sv
// Directed bench for fib_gen: reset, streaming, backpressure, ignored start,
// restart from DONE and asynchronous reset mid-run, with a term scoreboard.
module tb_fib_gen;
  import fib_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         ready = 1'b0;
  logic         valid;
  logic [W-1:0] fib;
  logic [W-1:0] idx;
  logic         done;
  fib_state_e   state_dbg;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_idx_q[$];
  int           checks = 0;
  int           errors = 0;
  int           last_idx = -1;
  int           xfers = 0;

  fib_gen #(.n(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .valid     (valid),
    .fib       (fib),
    .idx       (idx),
    .done      (done),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic is_fib(input logic [W-1:0] v);
    return v inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd13};
  endfunction

  task automatic push_sequence();
    logic [W-1:0] a;
    logic [W-1:0] nb;
    logic [W:0]   b;
    a = '0;
    b = 1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(a);
      exp_idx_q.push_back(W'(i));
      nb = b[W-1:0];
      b  = {1'b0, a} + b;
      a  = nb;
    end
    last_idx = -1;
  endtask

  // Score the term that will transfer on the coming edge.
  task automatic score_transfer();
    xfers++;
    if (exp_q.size() == 0) begin
      check("unexpected_term", 32'(fib), 32'hFFFF_FFFF);
    end else begin
      check("fib_term", 32'(fib), 32'(exp_q.pop_front()));
      check("idx_term", 32'(idx), 32'(exp_idx_q.pop_front()));
    end
    check("fib_member", 32'(is_fib(fib)), 32'd1);
    if (last_idx >= 0) check("idx_incr", 32'(idx), 32'(last_idx + 1));
    last_idx = int'(idx);
  endtask

  task automatic step();
    if (valid && ready) score_transfer();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_fib"}, 32'(fib), 32'd0);
    check({tag, "_idx"}, 32'(idx), 32'd0);
  endtask

  initial begin
    // Reset held with start and ready high
    #2;
    rst_n = 1'b0;
    start = 1'b1;
    ready = 1'b1;
    #1;
    check_idle_outputs("rst_async");
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle_outputs("rst_hold");
      check("rst_state", 32'(state_dbg), 32'(IDLE));
    end
    start = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_release_valid", 32'(valid), 32'd0);
    step();
    check_idle_outputs("idle_no_start");

    // Streaming with ready held high
    start = 1'b1;
    push_sequence();
    step();
    start = 1'b0;
    check("stream_first_valid", 32'(valid), 32'd1);
    xfers = 0;
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", 32'(valid), 32'd1);
      step();
    end
    check("stream_xfers", 32'(xfers), 32'd8);
    check("stream_done", 32'(done), 32'd1);
    check("stream_done_valid", 32'(valid), 32'd0);
    check("stream_last_fib", 32'(fib), 32'd13);
    check("stream_last_idx", 32'(idx), 32'd7);
    check("stream_q_empty", 32'(exp_q.size()), 32'd0);
    step();
    check("done_stays", 32'(done), 32'd1);

    // Restart from DONE, then backpressure at fib=2
    start = 1'b1;
    push_sequence();
    step();
    start = 1'b0;
    check("restart_valid", 32'(valid), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    check("restart_fib", 32'(fib), 32'd0);
    check("restart_idx", 32'(idx), 32'd0);
    for (int i = 0; i < 3; i++) step();
    check("bp_pre_fib", 32'(fib), 32'd2);
    check("bp_pre_idx", 32'(idx), 32'd3);
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_fib", 32'(fib), 32'd2);
      check("bp_hold_idx", 32'(idx), 32'd3);
      check("bp_hold_valid", 32'(valid), 32'd1);
    end
    ready = 1'b1;
    step();
    check("bp_resume_fib", 32'(fib), 32'd3);
    check("bp_resume_idx", 32'(idx), 32'd4);
    step();
    check("pre_ign_fib", 32'(fib), 32'd5);

    // start asserted during a transfer is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_fib8", 32'(fib), 32'd8);
    check("ign_idx6", 32'(idx), 32'd6);
    step();
    check("ign_fib13", 32'(fib), 32'd13);
    step();
    check("ign_done", 32'(done), 32'd1);
    check("ign_q_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between edges while fib=5
    start = 1'b1;
    push_sequence();
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("ar_pre_fib", 32'(fib), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("ar_async");
    check("ar_state", 32'(state_dbg), 32'(IDLE));
    exp_q.delete();
    exp_idx_q.delete();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ar_no_terms", 32'(valid), 32'd0);
    end

    // Fresh start after reset emits the full sequence again
    start = 1'b1;
    push_sequence();
    step();
    start = 1'b0;
    xfers = 0;
    for (int i = 0; i < 8; i++) step();
    check("final_xfers", 32'(xfers), 32'd8);
    check("final_done", 32'(done), 32'd1);
    check("final_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_gen.md
FIB_GEN -- requirements
Module: fib_gen

Interface
REQ-001 SHALL have parameter: n, 4, output word width in bits (n >= 2).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin a new sequence; sampled on clk.
REQ-005 SHALL have port: ready  input  1  consumer accepts current term this cycle.
REQ-006 SHALL have port: valid  output  1  fib/idx hold a term offered to the consumer.
REQ-007 SHALL have port: fib  output  n  current Fibonacci term, unsigned.
REQ-008 SHALL have port: idx  output  n  zero-based index of the current term.
REQ-009 SHALL have port: done  output  1  sequence exhausted; high only in DONE.
REQ-010 SHALL drive every output directly from registers, with no combinational path from inputs to outputs.

Function
REQ-011 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-012 IDLE: valid=0, done=0; when start=1, SHALL next enter RUN with fib=0, idx=0 and internal next-term register b=1.
REQ-013 RUN: valid SHALL be 1; a transfer occurs on any cycle with valid=1 and ready=1.
REQ-014 On a transfer, when b < 2^n, SHALL next set fib<=b, b<=fib+b (computed n+1 bits wide), idx<=idx+1; the next term is visible one cycle after the transfer.
REQ-015 On a transfer, when b >= 2^n (bit n set), SHALL next enter DONE; fib and idx keep the last transferred values.
REQ-016 RUN with ready=0: fib, idx, b and state SHALL hold unchanged; once valid is high, data stays stable until accepted.
REQ-017 start SHALL be ignored in RUN, including when asserted in the same cycle as a transfer.
REQ-018 DONE: valid=0, done=1; when start=1, SHALL next enter RUN with fib=0, idx=0, b=1, done=0.
REQ-019 When ready=1 continuously, back-to-back transfers SHALL occur every cycle, giving one term per cycle.
REQ-020 For n=4 the emitted sequence SHALL be exactly 0,1,1,2,3,5,8,13 with idx 0..7; the term 21 is never emitted.
REQ-021 The sum register SHALL be n+1 bits wide; no emitted term SHALL ever be truncated or wrapped.

Reset
REQ-022 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, valid=0, done=0, fib=0, idx=0, b=1.
REQ-023 Reset asserted mid-sequence SHALL abandon the sequence; after release, a new start is required to emit terms.
REQ-024 After rst_n deasserts, the first state change SHALL occur no earlier than the next rising clk edge.

Structure
REQ-025 A shared package fib_pkg SHALL hold the state typedef (IDLE, RUN, DONE with 2-bit encoding) and the default width constant.
REQ-026 No sub-module SHALL be required; the n+1-bit adder, FSM and registers SHALL all live in fib_gen.

Verification
REQ-027 Reset: hold rst_n=0 with start=1 and ready=1 -> valid=0, done=0, fib=0, idx=0 throughout.
REQ-028 Streaming: single-cycle start pulse, ready=1 constant -> fib 0,1,1,2,3,5,8,13 on 8 consecutive cycles, then done=1, valid=0.
REQ-029 Backpressure: ready=0 for 3 cycles while fib=2, idx=3 -> fib=2, idx=3, valid=1 held; fib=3 appears one cycle after ready returns to 1.
REQ-030 Ignored start: start=1 pulsed while fib=5 -> sequence continues with 8, 13 unchanged.
REQ-031 Restart: start=1 in DONE -> next cycle valid=1, fib=0, idx=0, done=0; full sequence repeats.
REQ-032 Async reset mid-run: drop rst_n between clk edges while fib=5 -> valid=0, fib=0 before the next edge; no terms until a new start.
REQ-033 Every transferred fib SHALL be checked against Fibonacci membership {0,1,2,3,5,8,13}, and idx SHALL be checked as strictly incrementing by 1 per transfer.
